// File: rtl/mem_pkg.sv
// Shared memory-path definitions: SPI SRAM opcodes, byte-mask codes, SPI FSM states.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package mem_pkg;

  localparam logic [7:0] SPI_CMD_READ  = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE = 8'h02;

  // Byte-mask codes, identical to the controller's funct3[1:0] width field.
  localparam logic [1:0] MASK_BYTE = 2'b00;
  localparam logic [1:0] MASK_HALF = 2'b01;
  localparam logic [1:0] MASK_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD,
    DONE
  } spi_state_t;

  // Total sclk periods in a frame: 8 cmd + 24 addr + 8 per data byte.
  function automatic logic [6:0] frame_bits(input logic [1:0] mask);
    case (mask)
      MASK_BYTE: return 7'd40;
      MASK_HALF: return 7'd48;
      default:   return 7'd64;
    endcase
  endfunction

  // Left-justify the received bytes so the first byte lands in [31:24].
  function automatic logic [31:0] place_rx(input logic [1:0] mask, input logic [31:0] rx);
    case (mask)
      MASK_BYTE: return {rx[7:0], 24'h000000};
      MASK_HALF: return {rx[15:0], 16'h0000};
      default:   return rx;
    endcase
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Reloadable down-counter that paces the SPI FSM; o_tick marks the last cycle of a phase.
// Latency: a load of V yields o_tick exactly V cycles later (V >= 1), counting the load cycle's successor as 1.
// Backpressure: none; the counter parks at zero with o_tick held until the next load.
module spi_clk_div (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  output logic       o_tick
);

  logic [7:0] r_cnt;

  // Reload on every phase change, otherwise count down and stop at zero.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_cnt <= 8'd0;
    end else if (i_load) begin
      r_cnt <= i_load_val - 8'd1;
    end else if (r_cnt != 8'd0) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  assign o_tick = (r_cnt == 8'd0);

endmodule

// File: rtl/sram_spi_master.sv
// Serial-SRAM SPI master (mode 0, 24-bit address): one latched load/store becomes one READ/WRITE frame.
// Latency: busy the cycle after req is sampled low; busy lasts CLK_DIV + 2*CLK_DIV*N + CE_HOLD cycles (N = 40/48/64).
// Backpressure: req is a level; releasing it mid-frame aborts, holding it low after completion parks in DONE.
module sram_spi_master
  import mem_pkg::*;
#(
  parameter int CLK_DIV = 1,
  parameter int CE_HOLD = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req,
  input  logic [23:0] i_addr,
  input  logic [1:0]  i_byte_mask,
  input  logic [31:0] i_data_in,
  input  logic        i_write,
  output logic [31:0] o_data_out,
  output logic        o_busy,
  output logic        o_valid,
  output logic        o_sclk,
  output logic        o_si,
  input  logic        i_so,
  output logic        o_ce
);

  localparam logic [7:0] DIV_VAL  = 8'(CLK_DIV);
  localparam logic [7:0] HOLD_VAL = 8'(CE_HOLD);

  spi_state_t r_state;
  spi_state_t w_state_nxt;

  logic [63:0] r_frame;
  logic [31:0] r_rx;
  logic [6:0]  r_bit_cnt;
  logic [1:0]  r_mask;
  logic        r_write;
  logic [31:0] r_data_out;

  logic       w_tick;
  logic       w_div_load;
  logic [7:0] w_div_val;
  logic       w_busy;
  logic       w_valid;
  logic       w_sclk;
  logic       w_ce;
  logic       w_si;
  logic       w_capture;
  logic       w_abort;
  logic       w_enter_high;
  logic       w_enter_low;
  logic       w_enter_hold;

  spi_clk_div u_clk_div (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_div_load),
    .i_load_val (w_div_val),
    .o_tick     (w_tick)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and pin decode; a high req in any active state aborts straight to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_valid     = 1'b0;
    w_sclk      = 1'b0;
    w_ce        = 1'b1;
    w_si        = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      IDLE: begin
        if (!i_req) w_state_nxt = SETUP;
      end
      SETUP: begin
        w_busy = 1'b1;
        w_ce   = 1'b0;
        w_si   = r_frame[63];
        if (i_req)       begin w_state_nxt = IDLE; w_abort = 1'b1; end
        else if (w_tick) w_state_nxt = HIGH;
      end
      HIGH: begin
        w_busy = 1'b1;
        w_ce   = 1'b0;
        w_sclk = 1'b1;
        w_si   = r_frame[63];
        if (i_req)       begin w_state_nxt = IDLE; w_abort = 1'b1; end
        else if (w_tick) w_state_nxt = LOW;
      end
      LOW: begin
        w_busy = 1'b1;
        w_ce   = 1'b0;
        w_si   = r_frame[63];
        if (i_req)       begin w_state_nxt = IDLE; w_abort = 1'b1; end
        else if (w_tick) w_state_nxt = (r_bit_cnt == 7'd0) ? HOLD : HIGH;
      end
      HOLD: begin
        w_busy = 1'b1;
        if (i_req)       begin w_state_nxt = IDLE; w_abort = 1'b1; end
        else if (w_tick) w_state_nxt = DONE;
      end
      DONE: begin
        w_valid = 1'b1;
        if (i_req) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Every phase change restarts the divider; only HOLD uses the chip-select hold count.
  assign w_div_load   = (w_state_nxt != r_state);
  assign w_div_val    = (w_state_nxt == HOLD) ? HOLD_VAL : DIV_VAL;
  assign w_capture    = (r_state == IDLE) && !i_req;
  assign w_enter_high = (r_state != HIGH) && (w_state_nxt == HIGH);
  assign w_enter_low  = (r_state == HIGH) && (w_state_nxt == LOW);
  assign w_enter_hold = (r_state == LOW)  && (w_state_nxt == HOLD);

  // Frame/receive datapath: latch request, shift on sclk phases, publish read data only at frame end.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_frame    <= 64'h0;
      r_rx       <= 32'h0;
      r_bit_cnt  <= 7'd0;
      r_mask     <= MASK_BYTE;
      r_write    <= 1'b0;
      r_data_out <= 32'h0;
    end else begin
      if (w_capture) begin
        r_frame    <= {(i_write ? SPI_CMD_WRITE : SPI_CMD_READ), i_addr, i_data_in};
        r_bit_cnt  <= frame_bits(i_byte_mask);
        r_mask     <= i_byte_mask;
        r_write    <= i_write;
        r_data_out <= 32'h0;
        r_rx       <= 32'h0;
      end
      // Every bit is shifted in; command/address-phase bits fall off the top before the frame ends.
      if (w_enter_high) begin
        r_rx <= {r_rx[30:0], i_so};
      end
      if (w_enter_low) begin
        r_frame   <= {r_frame[62:0], 1'b0};
        r_bit_cnt <= r_bit_cnt - 7'd1;
      end
      if (w_enter_hold && !r_write) begin
        r_data_out <= place_rx(r_mask, r_rx);
      end
      if (w_abort) begin
        r_data_out <= 32'h0;
      end
    end
  end

  assign o_data_out = r_data_out;
  assign o_busy     = w_busy;
  assign o_valid    = w_valid;
  assign o_sclk     = w_sclk;
  assign o_si       = w_si;
  assign o_ce       = w_ce;

endmodule

// File: tb/tb_sram_spi_master.sv
// Bench for sram_spi_master: two instances (CLK_DIV=1/CE_HOLD=1 and CLK_DIV=3/CE_HOLD=2) against a serial SRAM model.
// Latency: n/a.
// Backpressure: n/a.
module tb_sram_spi_master;

  localparam int DIV0 = 1, HOLD0 = 1, DIV1 = 3, HOLD1 = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = 2'b11;
  logic [23:0] addr = 24'h0;
  logic [1:0]  mask = 2'b00;
  logic [31:0] din = 32'h0;
  logic        wr = 1'b0;
  logic [31:0] dout0, dout1;
  logic [1:0]  busy, valid, sclk, si, ce;
  logic [1:0]  so = 2'b00;

  int checks = 0;
  int errors = 0;

  // Serial SRAM model state, one slot per DUT.
  logic [7:0]  mem [int];
  int          rise_cnt [2];
  int          ce_falls [2];
  int          stray [2];
  logic [63:0] mosi [2];
  logic [1:0]  sclk_q = 2'b00;
  logic [1:0]  ce_q = 2'b11;
  logic [7:0]  bv;
  int          off;

  always #5 clk = ~clk;

  sram_spi_master #(.CLK_DIV(DIV0), .CE_HOLD(HOLD0)) u_dut0 (
    .i_clk(clk), .i_reset(rst_n), .i_req(req[0]), .i_addr(addr), .i_byte_mask(mask),
    .i_data_in(din), .i_write(wr), .o_data_out(dout0), .o_busy(busy[0]), .o_valid(valid[0]),
    .o_sclk(sclk[0]), .o_si(si[0]), .i_so(so[0]), .o_ce(ce[0])
  );

  sram_spi_master #(.CLK_DIV(DIV1), .CE_HOLD(HOLD1)) u_dut1 (
    .i_clk(clk), .i_reset(rst_n), .i_req(req[1]), .i_addr(addr), .i_byte_mask(mask),
    .i_data_in(din), .i_write(wr), .o_data_out(dout1), .o_busy(busy[1]), .o_valid(valid[1]),
    .o_sclk(sclk[1]), .o_si(si[1]), .i_so(so[1]), .o_ce(ce[1])
  );

  function automatic logic [7:0] mem_rd(input int a);
    int k;
    k = a & 32'h00FF_FFFF;
    return mem.exists(k) ? mem[k] : 8'h00;
  endfunction

  // SRAM model: records MOSI on sclk rises under ce, serves read data MSB-first after the address.
  always @(sclk or ce) begin
    for (int g = 0; g < 2; g++) begin
      if (ce_q[g] === 1'b1 && ce[g] === 1'b0) begin
        rise_cnt[g] = 0;
        mosi[g]     = 64'h0;
        so[g]       = 1'b0;
        ce_falls[g]++;
      end
      if (sclk_q[g] === 1'b0 && sclk[g] === 1'b1) begin
        if (ce[g] === 1'b0) begin
          if (rise_cnt[g] < 64) mosi[g][63 - rise_cnt[g]] = si[g];
          rise_cnt[g]++;
          if (rise_cnt[g] >= 32 && rise_cnt[g] < 64 && mosi[g][63:56] == 8'h03) begin
            off   = rise_cnt[g] - 32;
            bv    = mem_rd(int'(mosi[g][55:32]) + off / 8);
            so[g] = bv[7 - (off % 8)];
          end else begin
            so[g] = 1'b0;
          end
        end else begin
          stray[g]++;
        end
      end
    end
    sclk_q = sclk;
    ce_q   = ce;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] get_dout(input int sel);
    return (sel == 1) ? dout1 : dout0;
  endfunction

  // Called at a negedge; drives the request immediately and follows the frame to completion.
  task automatic run_txn(input int sel, input logic w, input logic [23:0] a,
                         input logic [1:0] m, input logic [31:0] d);
    int nb, n, exp_busy, blen, falls0, div, hold;
    logic [31:0] exp_dout;
    logic [63:0] frame, fmask;
    div      = (sel == 1) ? DIV1 : DIV0;
    hold     = (sel == 1) ? HOLD1 : HOLD0;
    nb       = (m == 2'b00) ? 1 : (m == 2'b01) ? 2 : 4;
    n        = 32 + 8 * nb;
    exp_busy = div + n * 2 * div + hold;
    exp_dout = 32'h0;
    if (!w) for (int k = 0; k < nb; k++) exp_dout[31 - 8 * k -: 8] = mem_rd(int'(a) + k);
    frame  = {(w ? 8'h02 : 8'h03), a, d};
    fmask  = w ? (~64'h0 << (64 - n)) : {32'hFFFF_FFFF, 32'h0};
    falls0 = ce_falls[sel];
    addr = a; mask = m; din = d; wr = w;
    req[sel] = 1'b0;
    @(negedge clk);
    chk("busy_start", {63'h0, busy[sel]}, 64'h1);
    // Request inputs are scrambled once the frame is under way; the DUT must ignore them.
    addr = 24'($urandom); mask = 2'($urandom); din = $urandom; wr = 1'($urandom);
    blen = 0;
    while (busy[sel] === 1'b1 && blen < 4000) begin
      blen++;
      @(negedge clk);
    end
    chk("busy_len", 64'(blen), 64'(exp_busy));
    chk("valid_done", {63'h0, valid[sel]}, 64'h1);
    chk("data_out", {32'h0, get_dout(sel)}, {32'h0, exp_dout});
    chk("rises", 64'(rise_cnt[sel]), 64'(n));
    chk("mosi_bits", mosi[sel] & fmask, frame & fmask);
    chk("ce_falls", 64'(ce_falls[sel] - falls0), 64'h1);
    chk("ce_idle", {63'h0, ce[sel]}, 64'h1);
    chk("stray_sclk", 64'(stray[sel]), 64'h0);
  endtask

  // Parks in DONE for hold_cyc cycles, then releases req for exactly one cycle edge.
  task automatic finish_txn(input int sel, input int hold_cyc);
    int bad, falls0;
    bad    = 0;
    falls0 = ce_falls[sel];
    for (int i = 0; i < hold_cyc; i++) begin
      @(negedge clk);
      if (valid[sel] !== 1'b1 || busy[sel] !== 1'b0 || ce[sel] !== 1'b1) bad++;
    end
    if (hold_cyc > 0) begin
      chk("done_steady", 64'(bad), 64'h0);
      chk("no_restart", 64'(ce_falls[sel] - falls0), 64'h0);
    end
    req[sel] = 1'b1;
    @(negedge clk);
    chk("valid_clear", {63'h0, valid[sel]}, 64'h0);
  endtask

  initial begin
    int wt, vbad, falls0, sel;
    logic [23:0] ra;
    logic [1:0]  rm;
    logic        rw;
    for (int g = 0; g < 2; g++) begin
      rise_cnt[g] = 0; ce_falls[g] = 0; stray[g] = 0; mosi[g] = 64'h0;
    end

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_sclk", {62'h0, sclk}, 64'h0);
    chk("rst_ce", {62'h0, ce}, 64'h3);
    chk("rst_si", {62'h0, si}, 64'h0);
    chk("rst_busy", {62'h0, busy}, 64'h0);
    chk("rst_valid", {62'h0, valid}, 64'h0);
    chk("rst_dout", {dout1, dout0}, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Byte write, then hold req low after completion.
    run_txn(0, 1'b1, 24'h000123, 2'b00, 32'h5A00_0000);
    chk("wr_si_bytes", {24'h0, mosi[0][63:24]}, 64'h0000_0002_0001_235A);
    finish_txn(0, 20);

    // Word read at top of the address window.
    mem[32'h7FFFFC] = 8'hDE; mem[32'h7FFFFD] = 8'hAD;
    mem[32'h7FFFFE] = 8'hBE; mem[32'h7FFFFF] = 8'hEF;
    run_txn(0, 1'b0, 24'h7FFFFC, 2'b10, 32'h0);
    chk("rd_word_literal", {32'h0, dout0}, 64'hDEAD_BEEF);
    finish_txn(0, 2);

    // Halfword read, then mask 11 treated as a word.
    mem[32'h001000] = 8'h12; mem[32'h001001] = 8'h34;
    mem[32'h001002] = 8'h56; mem[32'h001003] = 8'h78;
    run_txn(0, 1'b0, 24'h001000, 2'b01, 32'h0);
    chk("rd_half_literal", {32'h0, dout0}, 64'h1234_0000);
    finish_txn(0, 1);
    run_txn(0, 1'b0, 24'h001000, 2'b11, 32'h0);
    finish_txn(0, 0);

    // Abort a read after 10 sclk rises.
    addr = 24'h7FFFFC; mask = 2'b10; wr = 1'b0; din = 32'h0;
    req[0] = 1'b0;
    wt = 0;
    while (!(ce[0] === 1'b0 && rise_cnt[0] == 10) && wt < 200) begin
      wt++;
      @(negedge clk);
    end
    chk("abort_reach10", 64'(rise_cnt[0]), 64'd10);
    req[0] = 1'b1;
    @(negedge clk);
    chk("abort_ce", {63'h0, ce[0]}, 64'h1);
    chk("abort_sclk", {63'h0, sclk[0]}, 64'h0);
    chk("abort_busy", {63'h0, busy[0]}, 64'h0);
    vbad = 0;
    falls0 = ce_falls[0];
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (valid[0] !== 1'b0 || dout0 !== 32'h0) vbad++;
    end
    chk("abort_no_valid", 64'(vbad), 64'h0);
    chk("abort_no_restart", 64'(ce_falls[0] - falls0), 64'h0);
    run_txn(0, 1'b0, 24'h7FFFFC, 2'b10, 32'h0);
    finish_txn(0, 0);

    // Slower instance: timing formula with CLK_DIV=3, CE_HOLD=2.
    run_txn(1, 1'b0, 24'h7FFFFC, 2'b10, 32'h0);
    chk("div3_rd_literal", {32'h0, dout1}, 64'hDEAD_BEEF);
    finish_txn(1, 20);
    run_txn(1, 1'b1, 24'hABCDEF, 2'b01, 32'hCAFE_0000);
    finish_txn(1, 1);

    // Randomized transactions on both instances.
    for (int t = 0; t < 12; t++) begin
      sel = int'($urandom_range(0, 1));
      ra  = 24'($urandom);
      rm  = 2'($urandom);
      rw  = 1'($urandom);
      for (int k = 0; k < 4; k++) mem[(int'(ra) + k) & 32'h00FF_FFFF] = 8'($urandom);
      run_txn(sel, rw, ra, rm, $urandom);
      finish_txn(sel, int'($urandom_range(0, 3)));
    end

    // Reset in the middle of a write at rise 20.
    addr = 24'h000456; mask = 2'b10; din = 32'h1122_3344; wr = 1'b1;
    req[0] = 1'b0;
    wt = 0;
    while (!(ce[0] === 1'b0 && rise_cnt[0] == 20) && wt < 200) begin
      wt++;
      @(negedge clk);
    end
    chk("rst_reach20", 64'(rise_cnt[0]), 64'd20);
    rst_n  = 1'b0;
    req[0] = 1'b1;
    @(negedge clk);
    chk("mid_rst_sclk", {63'h0, sclk[0]}, 64'h0);
    chk("mid_rst_ce", {63'h0, ce[0]}, 64'h1);
    chk("mid_rst_si", {63'h0, si[0]}, 64'h0);
    chk("mid_rst_busy", {63'h0, busy[0]}, 64'h0);
    chk("mid_rst_valid", {63'h0, valid[0]}, 64'h0);
    chk("mid_rst_dout", {32'h0, dout0}, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_rises", 64'(rise_cnt[0]), 64'd20);
    chk("post_rst_stray", 64'(stray[0]), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
